// File: rtl/gpioemu_pkg.sv
// Shared types and helpers for the GPIO-emulator arithmetic path:
// default widths, the job arbiter state encoding and a popcount helper.
package gpioemu_pkg;

  localparam int AW_DEF   = 24;
  localparam int WW_DEF   = 32;
  localparam int JOBCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    COUNT = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Callers zero-extend their word; WW is at most 2*AW = 48, so 6 bits cover it.
  function automatic logic [5:0] popcount(input logic [63:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/mul_seq_core.sv
// Iterative shift-add multiplier: one partial product per clock, AW clocks
// per job, a one-cycle done pulse after the last partial product.
module mul_seq_core #(
  parameter int AW = 24
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            start,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic            done,
  output logic [2*AW-1:0] acc
);

  localparam int CW = $clog2(AW);

  logic [2*AW-1:0] acc_q, acc_d;
  logic [2*AW-1:0] mcand_q, mcand_d;
  logic [AW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            done_q, done_d;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{AW{1'b0}}, a1};
      mplier_d = a2;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      // mcand_q holds a1 << k and mplier_q[0] holds a2[k] on cycle k.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == CW'(AW - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign acc  = acc_q;

endmodule

// File: rtl/mul_job_arbiter.sv
// Round-robin front end that shares one iterative multiplier among NREQ
// requesters and returns product word, popcount and overflow per job.
module mul_job_arbiter
  import gpioemu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int WW   = WW_DEF
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_a1,
  input  logic [NREQ*AW-1:0]       req_a2,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WW-1:0]            rsp_w,
  output logic [5:0]               rsp_l,
  output logic                     rsp_ovf,
  output logic                     busy,
  output logic [JOBCNT_W-1:0]      job_count
);

  localparam int IDW = $clog2(NREQ);

  arb_state_t          state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WW-1:0]       rsp_w_q, rsp_w_d;
  logic [5:0]          rsp_l_q, rsp_l_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic                busy_q, busy_d;
  logic [JOBCNT_W-1:0] job_count_q, job_count_d;

  logic                win_found;
  logic [IDW-1:0]      win_idx;
  logic [IDW:0]        cand;
  logic                grant;
  logic [AW-1:0]       a1_sel, a2_sel;
  logic                core_done;
  logic [2*AW-1:0]     core_acc;

  // First valid requester at or above the rr pointer, wrapping mod NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // Gated by n_reset so req_ready reads zero while reset is held.
  assign grant     = win_found && (state_q == IDLE) && n_reset;
  assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;
  assign a1_sel    = req_a1[win_idx*AW +: AW];
  assign a2_sel    = req_a2[win_idx*AW +: AW];

  mul_seq_core #(
    .AW (AW)
  ) u_core (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (grant),
    .a1      (a1_sel),
    .a2      (a2_sel),
    .done    (core_done),
    .acc     (core_acc)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_w_d     = rsp_w_q;
    rsp_l_d     = rsp_l_q;
    rsp_ovf_d   = rsp_ovf_q;
    job_count_d = job_count_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          id_d    = win_idx;
          rr_d    = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_d = MULT;
        end
      end
      MULT: begin
        if (core_done) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        rsp_w_d     = core_acc[WW-1:0];
        rsp_l_d     = popcount(64'(core_acc[WW-1:0]));
        rsp_ovf_d   = (core_acc >> WW) != '0;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // Response data is left in place after the handshake.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          job_count_d = job_count_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_w_q     <= '0;
      rsp_l_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_w_q     <= rsp_w_d;
      rsp_l_q     <= rsp_l_d;
      rsp_ovf_q   <= rsp_ovf_d;
      busy_q      <= busy_d;
      job_count_q <= job_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_w     = rsp_w_q;
  assign rsp_l     = rsp_l_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = busy_q;
  assign job_count = job_count_q;

endmodule
